// File: rtl/viterbi_pkg.sv
// Shared types, trellis constants and helpers for the Viterbi ACS scheduler.
// Optional feature macro: ACS_SCHED_NORM_EN (path-metric normalisation).
package viterbi_pkg;

    localparam int K     = 3;                  // constraint length
    localparam int WM    = 8;                  // path-metric width
    localparam int WB    = 2;                  // branch-metric width
    localparam int N_ST  = 1 << (K - 1);       // trellis states
    localparam int SW    = K - 1;              // state index width

    localparam logic [K-1:0] G0 = 3'b111;      // generator for c0
    localparam logic [K-1:0] G1 = 3'b101;      // generator for c1

    typedef logic [WM-1:0] pm_t;
    typedef logic [WB-1:0] bm_t;
    typedef logic [SW-1:0] state_t;

    localparam pm_t    INIT_PM  = 8'd64;       // start metric of every state but 0
    localparam state_t LAST_IDX = state_t'(N_ST - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } sched_state_e;

    // Expected code symbol {c0,c1} for the transition pred --u--> next.
    function automatic logic [1:0] exp_sym(input state_t pred, input logic u,
                                           input logic [K-1:0] g0,
                                           input logic [K-1:0] g1);
        logic [K-1:0] r;
        r = {pred, u};
        return {^(r & g0), ^(r & g1)};
    endfunction

    // Path metric plus branch metric, clamped at the all-ones metric.
    function automatic pm_t sat_add(input pm_t a, input bm_t b);
        logic [WM:0] sum;
        sum = {1'b0, a} + {{(WM - WB + 1){1'b0}}, b};
        return sum[WM] ? '1 : sum[WM-1:0];
    endfunction

endpackage

// File: rtl/acs_scheduler_acs_core.sv
// Two-input add-compare-select primitive; predecessor p0 wins ties.
module acs_core
    import viterbi_pkg::*;
(
    input  pm_t  pm0,
    input  pm_t  pm1,
    input  bm_t  bm0,
    input  bm_t  bm1,
    output pm_t  metric,
    output logic sel
);

    pm_t m0;
    pm_t m1;

    // Saturating adds, then pick p1 only when it is strictly better.
    always_comb begin
        m0     = sat_add(pm0, bm0);
        m1     = sat_add(pm1, bm1);
        sel    = (m1 < m0);
        metric = sel ? m1 : m0;
    end

endmodule

// File: rtl/acs_scheduler.sv
// Time-multiplexed ACS scheduler: one trellis state per cycle through a
// shared acs_core, ping-pong metric banks, survivor word + best state out.
// Optional feature macro: ACS_SCHED_NORM_EN subtracts the previous step's
// best metric (floored at 0) from predecessor metrics before ACS.
module acs_scheduler
    import viterbi_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_start,
    input  logic            bm_valid,
    output logic            bm_ready,
    input  logic [4*WB-1:0] bm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_ST-1:0] surv_word,
    output state_t          best_state,
    output pm_t             best_metric
);

    sched_state_e    state, state_nxt;
    state_t          idx;
    logic [4*WB-1:0] bm_q;
    pm_t             bank_a [N_ST];
    pm_t             bank_b [N_ST];
    logic            rd_sel;            // 0: read A / write B, 1: read B / write A
`ifdef ACS_SCHED_NORM_EN
    pm_t             norm_off;
`endif

    state_t p0, p1;
    logic   u;
    pm_t    pm0_rd, pm1_rd, pm0_in, pm1_in;
    bm_t    bm0, bm1;
    pm_t    acs_metric;
    logic   acs_sel;

    // Predecessor lookup, optional normalisation and branch-metric select for state idx.
    always_comb begin
        u      = idx[0];
        p0     = {1'b0, idx[SW-1:1]};
        p1     = {1'b1, idx[SW-1:1]};
        pm0_rd = rd_sel ? bank_b[p0] : bank_a[p0];
        pm1_rd = rd_sel ? bank_b[p1] : bank_a[p1];
`ifdef ACS_SCHED_NORM_EN
        pm0_in = (pm0_rd > norm_off) ? pm0_rd - norm_off : '0;
        pm1_in = (pm1_rd > norm_off) ? pm1_rd - norm_off : '0;
`else
        pm0_in = pm0_rd;
        pm1_in = pm1_rd;
`endif
        bm0    = bm_q[int'(exp_sym(p0, u, G0, G1)) * WB +: WB];
        bm1    = bm_q[int'(exp_sym(p1, u, G0, G1)) * WB +: WB];
    end

    acs_core u_acs (
        .pm0    (pm0_in),
        .pm1    (pm1_in),
        .bm0    (bm0),
        .bm1    (bm1),
        .metric (acs_metric),
        .sel    (acs_sel)
    );

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        bm_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bm_ready = 1'b1;
                if (!frame_start && bm_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: metric banks, index counter, survivor word and min tracker.
    // NOTE: the metric banks are small register arrays and must hold defined start metrics, so they are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            bm_q        <= '0;
            rd_sel      <= 1'b0;
            surv_word   <= '0;
            best_state  <= '0;
            best_metric <= '0;
`ifdef ACS_SCHED_NORM_EN
            norm_off    <= '0;
`endif
            for (int i = 0; i < N_ST; i++) begin
                bank_a[i] <= (i == 0) ? '0 : INIT_PM;
                bank_b[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        for (int i = 0; i < N_ST; i++) begin
                            if (rd_sel) bank_b[i] <= (i == 0) ? '0 : INIT_PM;
                            else        bank_a[i] <= (i == 0) ? '0 : INIT_PM;
                        end
`ifdef ACS_SCHED_NORM_EN
                        norm_off <= '0;
`endif
                    end else if (bm_valid) begin
                        bm_q <= bm;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    if (rd_sel) bank_a[idx] <= acs_metric;
                    else        bank_b[idx] <= acs_metric;
                    surv_word[idx] <= acs_sel;
                    if ((idx == '0) || (acs_metric < best_metric)) begin
                        best_metric <= acs_metric;
                        best_state  <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        rd_sel <= ~rd_sel;
`ifdef ACS_SCHED_NORM_EN
                        norm_off <= best_metric;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Scoreboard bench for acs_scheduler: randomized and directed symbols are
// scored against a trellis reference model; a monitor pops expectations on
// every output handshake. ACS_SCHED_NORM_EN selects the normalising model.
module tb_acs_scheduler;
    import viterbi_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            bm_valid = 1'b0;
    logic            bm_ready;
    logic [4*WB-1:0] bm = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N_ST-1:0] surv_word;
    state_t          best_state;
    pm_t             best_metric;

    acs_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bm_valid    (bm_valid),
        .bm_ready    (bm_ready),
        .bm          (bm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .surv_word   (surv_word),
        .best_state  (best_state),
        .best_metric (best_metric)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_ST-1:0] surv;
        int              bst;
        int              bmet;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_count = 0;
    int   last_bm = 0;
    int   last_bs = 0;

    // Reference model: metrics as plain integers.
    int mpm [N_ST];
    int moff;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void model_init();
        for (int s = 0; s < N_ST; s++) mpm[s] = (s == 0) ? 0 : int'(INIT_PM);
        moff = 0;
    endfunction

    // One trellis step from the encoder's point of view; pushes the expectation.
    function automatic void model_step(input logic [4*WB-1:0] bmv);
        int   newpm [N_ST];
        exp_t e;
        int   best;
        e.surv = '0;
        best   = 0;
        for (int s = 0; s < N_ST; s++) begin
            int cand [2];
            for (int b = 0; b < 2; b++) begin
                int pred, r, c0, c1, base;
                pred = b * (N_ST / 2) + s / 2;
                r    = pred * 2 + (s % 2);
                c0   = $countones(r & int'(G0)) % 2;
                c1   = $countones(r & int'(G1)) % 2;
                base = mpm[pred] - moff;
                if (base < 0) base = 0;
                cand[b] = base + int'(bmv[(c0 * 2 + c1) * WB +: WB]);
                if (cand[b] > 255) cand[b] = 255;
            end
            e.surv[s] = (cand[1] < cand[0]);
            newpm[s]  = e.surv[s] ? cand[1] : cand[0];
            if (s == 0 || newpm[s] < newpm[best]) best = s;
        end
        for (int s = 0; s < N_ST; s++) mpm[s] = newpm[s];
        e.bst  = best;
        e.bmet = newpm[best];
`ifdef ACS_SCHED_NORM_EN
        moff = newpm[best];
`endif
        sb_q.push_back(e);
    endfunction

    // Monitor: every accepted output is scored against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            mon_count++;
            check("sb_has_entry", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("surv_word",   int'(surv_word),   int'(e.surv));
                check("best_state",  int'(best_state),  e.bst);
                check("best_metric", int'(best_metric), e.bmet);
            end
            last_bm = int'(best_metric);
            last_bs = int'(best_state);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bm_ready && n < 50) begin
            tick();
            n++;
        end
        check("bm_ready_timeout", int'(bm_ready), 1);
    endtask

    // Issue one symbol and wait for its output handshake.
    task automatic send_sym(input logic [4*WB-1:0] bmv);
        int start, n;
        wait_ready();
        bm       = bmv;
        bm_valid = 1'b1;
        model_step(bmv);
        start = mon_count;
        tick();
        bm_valid = 1'b0;
        bm       = 8'($urandom);
        n = 0;
        while (mon_count == start && n < 100) begin
            tick();
            n++;
        end
        check("out_handshake", mon_count - start, 1);
    endtask

    // frame_start together with bm_valid: re-init wins, nothing accepted.
    task automatic pulse_frame_start();
        wait_ready();
        frame_start = 1'b1;
        bm_valid    = 1'b1;
        bm          = 8'($urandom);
        model_init();
        tick();
        frame_start = 1'b0;
        bm_valid    = 1'b0;
        check("fs_stays_idle", int'(bm_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              n, st, lat;
        logic [4*WB-1:0] bmv;
        logic [N_ST-1:0] hold_surv;
        state_t          hold_bs;
        pm_t             hold_bm;

        // Reset state.
        model_init();
        #12;
        check("rst_bm_ready",  int'(bm_ready),    1);
        check("rst_out_valid", int'(out_valid),   0);
        check("rst_surv",      int'(surv_word),   0);
        check("rst_best_st",   int'(best_state),  0);
        check("rst_best_met",  int'(best_metric), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: all-zero set, latency from the accept edge to out_valid.
        bm       = '0;
        bm_valid = 1'b1;
        model_step('0);
        tick();
        bm_valid = 1'b0;
        lat = 1;
        check("run_bm_ready", int'(bm_ready), 0);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, N_ST + 1);
        tick();
        check("t1_done", mon_count, 1);

        // Test 2: ideal metrics for encoded bits 1,0,1,1.
        pulse_frame_start();
        st = 0;
        for (int k = 0; k < 4; k++) begin
            int u, r, rx;
            u  = (k == 1) ? 0 : 1;
            r  = st * 2 + u;
            rx = ($countones(r & int'(G0)) % 2) * 2 + ($countones(r & int'(G1)) % 2);
            for (int i = 0; i < 4; i++) begin
                int d;
                d = 2 * $countones(i ^ rx);
                if (d > 3) d = 3;
                bmv[i * WB +: WB] = WB'(d);
            end
            st = r % N_ST;
            send_sym(bmv);
            check("t2_metric", last_bm, 0);
        end
        check("t2_final_state", last_bs, 3);

        // Test 3: backpressure in OUT; bm_valid pulses must be ignored.
        wait_ready();
        out_ready = 1'b0;
        bmv       = 8'($urandom);
        bm        = bmv;
        bm_valid  = 1'b1;
        model_step(bmv);
        tick();
        bm_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("t3_out_valid", int'(out_valid), 1);
        hold_surv = surv_word;
        hold_bs   = best_state;
        hold_bm   = best_metric;
        n = mon_count;
        for (int c = 0; c < 10; c++) begin
            bm_valid = 1'($urandom);
            bm       = 8'($urandom);
            tick();
            check("t3_hold_valid", int'(out_valid),   1);
            check("t3_hold_ready", int'(bm_ready),    0);
            check("t3_hold_surv",  int'(surv_word),   int'(hold_surv));
            check("t3_hold_bs",    int'(best_state),  int'(hold_bs));
            check("t3_hold_bm",    int'(best_metric), int'(hold_bm));
        end
        bm_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("t3_released", mon_count - n, 1);

        // Randomized symbols with occasional frame re-init.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(7) == 0) pulse_frame_start();
            send_sym(8'($urandom));
        end

        // Test 4/5: long run of worst-case metrics.
        pulse_frame_start();
        for (int k = 0; k < 200; k++) send_sym(8'hFF);
`ifdef ACS_SCHED_NORM_EN
        check("t5_bounded", int'(last_bm <= int'(INIT_PM) + 6), 1);
`else
        check("t4_clamped", last_bm, 255);
`endif

        // Test 6: reset in the middle of RUN at idx 2.
        wait_ready();
        bm       = 8'($urandom);
        bm_valid = 1'b1;
        model_step(bm);
        tick();
        bm_valid = 1'b0;
        tick();
        tick();
        n = mon_count;
        rst_n = 1'b0;
        sb_q.delete();
        model_init();
        #1;
        check("t6_bm_ready",  int'(bm_ready),    1);
        check("t6_out_valid", int'(out_valid),   0);
        check("t6_surv",      int'(surv_word),   0);
        check("t6_best_met",  int'(best_metric), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_stale", mon_count - n, 0);
        send_sym('0);
        check("t6_reinit_metric", last_bm, 0);
        send_sym(8'($urandom));
        check("t6_sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
